// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared types and constants for the SNN stimulus datapath.
//                Provides the default intensity width, the rate-encoder
//                state encoding and the intensity sample type.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    // Intensity / threshold / leak_factor width across the datapath
    localparam int SNN_DATA_W = 16;

    // Rate-encoder control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } enc_state_e;

    typedef logic [SNN_DATA_W-1:0] intensity_t;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/spike_phase_acc.sv
`default_nettype none
// ============================================================================
//  Module      : spike_phase_acc
//  Description : Phase accumulator spike generator. Each enabled cycle adds
//                the intensity to a DATA_W-bit accumulator that wraps modulo
//                2^DATA_W; the carry out becomes the registered spike.
//                Spike density is therefore intensity / 2^DATA_W per cycle.
//  Ports       : clk       - system clock, rising edge
//                rst       - asynchronous active-high reset
//                clr       - synchronous clear of accumulator and spike
//                            (takes priority over en)
//                en        - perform one accumulate step
//                intensity - increment added per step
//                spike     - registered carry of the last step
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_phase_acc
    import snn_pkg::*;
#(
    parameter int DATA_W = SNN_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] intensity,
    output logic              spike
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic              spike_q;
    logic              spike_d;
    logic [DATA_W:0]   w_sum;

    always_comb begin
        w_sum   = {1'b0, acc_q} + {1'b0, intensity};
        acc_d   = acc_q;
        spike_d = spike_q;
        if (clr) begin
            acc_d   = '0;
            spike_d = 1'b0;
        end else if (en) begin
            // Dropping the MSB gives the modulo-2^DATA_W wrap; the MSB is the carry
            acc_d   = w_sum[DATA_W-1:0];
            spike_d = w_sum[DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule : spike_phase_acc
`default_nettype wire

// File: rtl/lif_rate_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lif_rate_encoder
//  Description : Rate-coded spike generator feeding the LIF neuron. Accepts
//                one intensity sample per valid/ready handshake and emits a
//                deterministic spike train for WINDOW_LEN cycles, then pulses
//                window_done and reports the number of spikes emitted.
//  Ports       : clk, rst     - clock (rising edge), async active-high reset
//                in_valid     - intensity sample valid
//                in_ready     - encoder idle and able to accept a sample
//                in_intensity - unsigned intensity, 0 = silent
//                flush        - synchronous abort of the current window
//                input_spike  - registered spike train to the neuron
//                busy         - window in progress
//                window_done  - one-cycle pulse at window end
//                spike_count  - spikes in the last completed window
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_rate_encoder
    import snn_pkg::*;
#(
    parameter int DATA_W     = SNN_DATA_W,
    parameter int WINDOW_LEN = 256,
    parameter int CNT_W      = $clog2(WINDOW_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_intensity,
    input  logic              flush,
    output logic              input_spike,
    output logic              busy,
    output logic              window_done,
    output logic [CNT_W-1:0]  spike_count
);

    localparam logic [CNT_W-1:0] c_last_cyc = CNT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    enc_state_e        state_q, state_d;
    logic [DATA_W-1:0] intensity_q, intensity_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  spk_q, spk_d;
    logic [CNT_W-1:0]  spike_count_q, spike_count_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              window_done_q, window_done_d;

    logic              w_accept;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic [DATA_W-1:0] w_acc_in;
    logic [CNT_W-1:0]  w_spk_next;

    // The accumulator already steps once on the handshake edge so that the
    // first window cycle's spike is on input_spike in the cycle right after
    // the handshake. It is cleared on every window exit, so it is zero in IDLE.
    spike_phase_acc #(
        .DATA_W (DATA_W)
    ) u_phase_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_acc_clr),
        .en        (w_acc_en),
        .intensity (w_acc_in),
        .spike     (input_spike)
    );

    always_comb begin
        state_d       = state_q;
        intensity_d   = intensity_q;
        cyc_d         = cyc_q;
        spk_d         = spk_q;
        spike_count_d = spike_count_q;
        w_acc_clr     = 1'b0;
        w_acc_en      = 1'b0;
        w_acc_in      = intensity_q;
        // spk counts spikes already shown; add the one on the output this cycle
        w_spk_next    = spk_q + (input_spike ? c_one : '0);
        // flush wins over a simultaneous in_valid
        w_accept      = in_valid && in_ready_q && !flush;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d     = ACTIVE;
                    intensity_d = in_intensity;
                    cyc_d       = '0;
                    spk_d       = '0;
                    w_acc_en    = 1'b1;
                    w_acc_in    = in_intensity;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_d   = IDLE;
                    cyc_d     = '0;
                    spk_d     = '0;
                    w_acc_clr = 1'b1;
                end else begin
                    cyc_d = cyc_q + c_one;
                    spk_d = w_spk_next;
                    if (cyc_q == c_last_cyc) begin
                        // Last window cycle: the step computed now would belong
                        // to the next window, so clear instead of stepping.
                        state_d       = DONE;
                        spike_count_d = w_spk_next;
                        w_acc_clr     = 1'b1;
                    end else begin
                        w_acc_en = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                w_acc_clr = 1'b1;
            end
        endcase

        in_ready_d    = (state_d == IDLE);
        busy_d        = (state_d == ACTIVE);
        window_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            intensity_q   <= '0;
            cyc_q         <= '0;
            spk_q         <= '0;
            spike_count_q <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            intensity_q   <= intensity_d;
            cyc_q         <= cyc_d;
            spk_q         <= spk_d;
            spike_count_q <= spike_count_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            window_done_q <= window_done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign window_done = window_done_q;
    assign spike_count = spike_count_q;

endmodule : lif_rate_encoder
`default_nettype wire

// File: tb/tb_lif_rate_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_rate_encoder
//  Description : Scoreboard bench for lif_rate_encoder. Stimulus pushes the
//                expected spike mask and count of every window that should
//                complete; a monitor captures the spike train while busy and
//                compares when window_done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_rate_encoder;

    localparam int W     = 256;
    localparam int CW    = 9;

    typedef struct {
        int           count;
        logic [W:0]   mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_intensity;
    logic          flush;
    logic          input_spike;
    logic          busy;
    logic          window_done;
    logic [CW-1:0] spike_count;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   stray  = 0;

    always #5 clk = ~clk;

    lif_rate_encoder #(
        .DATA_W     (16),
        .WINDOW_LEN (W),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_intensity (in_intensity),
        .flush        (flush),
        .input_spike  (input_spike),
        .busy         (busy),
        .window_done  (window_done),
        .spike_count  (spike_count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Spike in window cycle j when floor(j*I/2^16) steps up
    function automatic logic [W:0] exp_mask(input longint i);
        logic [W:0] m;
        m = '0;
        for (int j = 1; j <= W; j++)
            m[j] = ((longint'(j) * i) >> 16) != ((longint'(j - 1) * i) >> 16);
        return m;
    endfunction

    task automatic push_exp(input logic [15:0] i, input int cnt);
        exp_t e;
        e.count = cnt;
        e.mask  = exp_mask(longint'(i));
        sb.push_back(e);
    endtask

    // Called on a negedge; returns on the negedge right after the handshake edge
    task automatic start(input logic [15:0] i);
        int n;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("start_in_ready", longint'(in_ready), 1);
        in_valid     = 1'b1;
        in_intensity = i;
        @(negedge clk);
        in_valid     = 1'b0;
    endtask

    // Counts negedges after the handshake edge until in_ready is seen high
    task automatic wait_ready(output int n);
        n = 1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        int         j;
        logic [W:0] cap;
        exp_t       e;
        j   = 0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                j   = 0;
                cap = '0;
            end else begin
                if (busy) begin
                    j++;
                    if (j <= W) cap[j] = input_spike;
                end else if (input_spike) begin
                    stray++;
                end
                if (window_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_window_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("spike_count", longint'(spike_count), longint'(e.count));
                        check("window_len", longint'(j), longint'(W));
                        checks++;
                        if (cap !== e.mask) begin
                            errors++;
                            $display("FAIL spike_mask: got %h expected %h", cap, e.mask);
                        end
                    end
                    j   = 0;
                    cap = '0;
                end else if (!busy && j != 0) begin
                    j   = 0;
                    cap = '0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int cnt;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_intensity = '0;
        flush        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",    longint'(in_ready), 0);
        check("rst_input_spike", longint'(input_spike), 0);
        check("rst_busy",        longint'(busy), 0);
        check("rst_window_done", longint'(window_done), 0);
        check("rst_spike_count", longint'(spike_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Reset in the middle of a window (window cycle 100)
        start(16'h8000);
        repeat (99) @(negedge clk);
        check("mid_busy_before_rst", longint'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_input_spike", longint'(input_spike), 0);
        check("mid_rst_busy",        longint'(busy), 0);
        check("mid_rst_window_done", longint'(window_done), 0);
        check("mid_rst_spike_count", longint'(spike_count), 0);
        check("mid_rst_in_ready",    longint'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_in_ready", longint'(in_ready), 1);

        // Silent intensity: full window, zero spikes, exact turnaround
        push_exp(16'h0000, 0);
        start(16'h0000);
        wait_ready(n);
        check("i0_ready_latency", longint'(n), 258);

        // Quarter intensity: every 4th cycle
        push_exp(16'h4000, 64);
        start(16'h4000);
        wait_ready(n);
        check("i4000_ready_latency", longint'(n), 258);

        // Half intensity, then full-scale back-to-back
        push_exp(16'h8000, 128);
        start(16'h8000);
        wait_ready(n);
        check("i8000_ready_latency", longint'(n), 258);
        push_exp(16'hFFFF, 255);
        start(16'hFFFF);
        wait_ready(n);
        check("iffff_ready_latency", longint'(n), 258);

        // Flush at window cycle 50
        start(16'h8000);
        repeat (49) @(negedge clk);
        check("flush_spike_c50", longint'(input_spike), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", longint'(busy), 0);
        check("flush_in_ready", longint'(in_ready), 1);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (input_spike || window_done) cnt++;
            @(negedge clk);
        end
        check("flush_quiet", longint'(cnt), 0);
        check("flush_spike_count_held", longint'(spike_count), 255);

        // flush together with in_valid in IDLE: no acceptance
        in_valid     = 1'b1;
        flush        = 1'b1;
        in_intensity = 16'h4000;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_valid_busy", longint'(busy), 0);
        check("flush_valid_in_ready", longint'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("flush_valid_still_idle", longint'(busy), 0);

        // Handshake hygiene: valid held with changing data during the window
        in_valid     = 1'b1;
        in_intensity = 16'h4000;
        push_exp(16'h4000, 64);
        @(negedge clk);
        n = 1;
        while (!in_ready && n < 2000) begin
            in_intensity = 16'(n * 16'h0101 + 16'h7FFF);
            @(negedge clk);
            n++;
        end
        check("hyg_ready_latency", longint'(n), 258);
        in_intensity = 16'h8000;
        push_exp(16'h8000, 128);
        @(negedge clk);
        in_valid = 1'b0;
        check("hyg_second_accepted", longint'(busy), 1);
        wait_ready(n);
        check("hyg2_ready_latency", longint'(n), 258);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);
        check("stray_spikes", longint'(stray), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_lif_rate_encoder
`default_nettype wire

// File: doc/lif_rate_encoder.md
Name: lif_rate_encoder

Overview:
- Rate-coded spike generator at the stimulus end of the LIF neuron datapath.
- Accepts one intensity sample per valid/ready handshake and emits a deterministic spike train on input_spike over a fixed window of WINDOW_LEN cycles.
- input_spike connects directly to the neuron's input_spike port.
- At window end, reports the number of spikes emitted.

Parameters:
DATA_W, 16, intensity width; matches the neuron threshold/leak_factor width
WINDOW_LEN, 256, cycles per encoding window; must be >= 2
CNT_W, $clog2(WINDOW_LEN+1), width of window cycle counter and spike_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  intensity sample valid
in_ready  output  1  encoder can accept a sample
in_intensity  input  DATA_W  unsigned intensity, 0 = silent
flush  input  1  synchronous abort of the current window
input_spike  output  1  spike train to the neuron, registered
busy  output  1  window in progress
window_done  output  1  one-cycle pulse at window end
spike_count  output  CNT_W  spikes emitted in the last completed window; held until next window_done

Behaviour:
- Reset (async, rst=1): state IDLE; acc, cycle counter and latched intensity cleared. Outputs while reset is high: in_ready=0, input_spike=0, busy=0, window_done=0, spike_count=0. After reset deasserts: in_ready=1 from the first clock edge.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - in_ready=1, busy=0, input_spike=0.
  - Handshake occurs when in_valid && in_ready at a rising edge: latch in_intensity, acc<=0, cyc<=0, spk<=0, go to ACTIVE.
- ACTIVE:
  - in_ready=0, busy=1.
  - Each cycle: {carry, acc_next} = acc + intensity, computed as a DATA_W+1-bit sum; acc wraps modulo 2^DATA_W.
  - input_spike is registered from carry.
  - spk increments on carry; cyc increments every cycle.
  - When cyc reaches WINDOW_LEN-1 and that cycle's update is done, go to DONE.
- DONE (one cycle):
  - window_done=1, input_spike=0.
  - spike_count <= spk (visible from this cycle).
  - Go to IDLE.
- Timing: handshake at edge N → input_spike valid during cycles N+1 .. N+WINDOW_LEN → window_done during cycle N+WINDOW_LEN+1 → in_ready=1 during cycle N+WINDOW_LEN+2.
- Spike count equals floor(WINDOW_LEN*I / 2^DATA_W). Spike k is emitted in window cycle j exactly when floor(j*I/2^DATA_W) > floor((j-1)*I/2^DATA_W), for j = 1..WINDOW_LEN.
- I=0: zero spikes; window still runs and window_done still pulses with spike_count=0.
- I=2^DATA_W-1: WINDOW_LEN-1 spikes; no spike in the first window cycle.
- flush:
  - In ACTIVE: next state IDLE, input_spike=0 next cycle. No window_done; spike_count unchanged.
  - In IDLE or DONE: no effect, except flush and in_valid together in IDLE: flush wins, no handshake, in_ready remains 1.
- in_valid while not ready: ignored. The sample must be held by the source.
- Reset mid-window: immediate abort; all outputs take their reset values.
- spk and cyc never overflow: CNT_W holds WINDOW_LEN.

Decomposition:
- Package snn_pkg:
  - SNN_DATA_W = 16
  - typedef enc_state_e {IDLE, ACTIVE, DONE}
  - typedef logic [SNN_DATA_W-1:0] intensity_t
- Sub-module spike_phase_acc:
  - Contains the DATA_W accumulator, carry generation and registered spike output.
  - Ports: clk, rst, clr, en, intensity, spike.
  - Reusable by a future Poisson/LFSR encoder variant.
- FSM, counters and handshake stay in lif_rate_encoder.

Test Plan:
- Reset during ACTIVE (I=0x8000, rst asserted at window cycle 100): input_spike, busy, window_done, spike_count all 0 immediately; in_ready=1 on first edge after release.
- I=0x0000: 256 cycles busy, zero spikes, window_done pulse with spike_count=0; in_ready returns exactly 258 cycles after the handshake.
- I=0x4000: spikes on window cycles 4, 8, …, 256 (every 4th cycle); spike_count=64.
- I=0x8000: alternating spikes starting at window cycle 2, 128 total; then I=0xFFFF sent back-to-back when in_ready rises: 255 spikes, none in cycle 1.
- Flush at window cycle 50 with I=0x8000: input_spike=0 from cycle 51, no window_done, spike_count keeps the previous value. Flush asserted together with in_valid in IDLE: no acceptance.
- Handshake hygiene: in_valid held high during ACTIVE with a changing intensity. Only the sample accepted in IDLE is encoded; the next sample is accepted only at the first in_ready cycle after window_done.
